// File: rtl/sm83_alu_nibble_seq_pkg.sv
// ---------------------------------------------------------------------------
// sm83_alu_pkg
// Shared types and constants for the SM83 nibble-serial ALU sequencer.
//   alu_op_t        : ALU operation codes as driven by CPU control
//   alu_seq_state_t : sequencer states (idle, low-nibble pass, high-nibble pass)
//   DAA_*_CORR      : decimal-adjust correction constants
//   decodeOp        : maps a raw 4-bit opcode onto alu_op_t (unknown -> OR)
// ---------------------------------------------------------------------------
package sm83_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_XOR = 4'd5,
        ALU_OR  = 4'd6,
        ALU_CP  = 4'd7,
        ALU_DAA = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } alu_seq_state_t;

    localparam logic [7:0] DAA_LO_CORR = 8'h06;
    localparam logic [7:0] DAA_HI_CORR = 8'h60;

    // Opcodes 9..15 have no operation of their own and behave as OR.
    function automatic alu_op_t decodeOp(input logic [3:0] rawOp);
        alu_op_t decoded;
        case (rawOp)
            4'd0:    decoded = ALU_ADD;
            4'd1:    decoded = ALU_ADC;
            4'd2:    decoded = ALU_SUB;
            4'd3:    decoded = ALU_SBC;
            4'd4:    decoded = ALU_AND;
            4'd5:    decoded = ALU_XOR;
            4'd7:    decoded = ALU_CP;
            4'd8:    decoded = ALU_DAA;
            default: decoded = ALU_OR;
        endcase
        return decoded;
    endfunction

endpackage

// File: rtl/sm83_alu_nibble_seq_if.sv
// ---------------------------------------------------------------------------
// sm83_alu_nibble_seq_if
// Request/result bundle between CPU control and the nibble-serial ALU.
//   master : CPU control side (drives start, op, operands, current flags)
//   slave  : ALU sequencer side (drives ready, result, flag outputs)
// Signals:
//   start/ready                        request handshake
//   op, a, b                           operation and operands
//   carry_flag/half_carry_flag/neg_flag current C/H/N flags
//   result, result_we, done            result word, write enable, done pulse
//   zero_out/carry_out/half_carry_out/daa_carry_out  ALU-side flag inputs
// ---------------------------------------------------------------------------
interface sm83_alu_nibble_seq_if #(
    parameter int WORD_SIZE = 8
);
    logic                 start;
    logic                 ready;
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic                 carry_flag;
    logic                 half_carry_flag;
    logic                 neg_flag;
    logic [WORD_SIZE-1:0] result;
    logic                 result_we;
    logic                 done;
    logic                 zero_out;
    logic                 carry_out;
    logic                 half_carry_out;
    logic                 daa_carry_out;

    modport master (
        output start, op, a, b, carry_flag, half_carry_flag, neg_flag,
        input  ready, result, result_we, done,
               zero_out, carry_out, half_carry_out, daa_carry_out
    );

    modport slave (
        input  start, op, a, b, carry_flag, half_carry_flag, neg_flag,
        output ready, result, result_we, done,
               zero_out, carry_out, half_carry_out, daa_carry_out
    );
endinterface

// File: rtl/sm83_alu_nibble.sv
// ---------------------------------------------------------------------------
// sm83_alu_nibble
// Combinational 4-bit add/logic slice shared by both nibble passes.
//   i_a, i_b : nibble operands (i_b already inverted/corrected by the caller)
//   i_cin    : carry into the slice
//   i_op     : operation; every arithmetic op is a plain add here
//   o_sum    : nibble result
//   o_cout   : carry out of the slice (0 for logical ops)
//   o_zero   : o_sum == 0
// ---------------------------------------------------------------------------
module sm83_alu_nibble
    import sm83_alu_pkg::*;
#(
    parameter int NIBBLE = 4
) (
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_cin,
    input  alu_op_t           i_op,
    output logic [NIBBLE-1:0] o_sum,
    output logic              o_cout,
    output logic              o_zero
);

    logic [NIBBLE:0]   w_wide;
    logic [NIBBLE-1:0] w_sum;
    logic              w_cout;

    // Subtraction and DAA are folded into addition by the sequencer, so the
    // slice only needs an adder plus the three bitwise functions.
    always_comb begin
        w_wide = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE{1'b0}}, i_cin};
        w_sum  = w_wide[NIBBLE-1:0];
        w_cout = w_wide[NIBBLE];
        case (i_op)
            ALU_AND: begin
                w_sum  = i_a & i_b;
                w_cout = 1'b0;
            end
            ALU_XOR: begin
                w_sum  = i_a ^ i_b;
                w_cout = 1'b0;
            end
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_CP, ALU_DAA: begin
                w_sum  = w_wide[NIBBLE-1:0];
                w_cout = w_wide[NIBBLE];
            end
            default: begin
                w_sum  = i_a | i_b;
                w_cout = 1'b0;
            end
        endcase
    end

    assign o_sum  = w_sum;
    assign o_cout = w_cout;
    assign o_zero = (w_sum == '0);

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// ---------------------------------------------------------------------------
// sm83_alu_nibble_seq
// Nibble-serial 8-bit ALU sequencer for the SM83 core. An accepted request
// runs a low-nibble pass then a high-nibble pass through one 4-bit slice and
// pulses done with the result and the ALU-side flag inputs.
//   clk    : core clock
//   nreset : asynchronous active-low reset
//   alu    : slave side of sm83_alu_nibble_seq_if (handshake, operands,
//            current flags in; result, result_we, done, flag outputs out)
// ---------------------------------------------------------------------------
module sm83_alu_nibble_seq
    import sm83_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NIBBLE    = 4
) (
    input  logic                   clk,
    input  logic                   nreset,
    sm83_alu_nibble_seq_if.slave   alu
);

    alu_seq_state_t       r_state;
    alu_seq_state_t       w_nextState;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_loadLo;
    logic                 w_loadHi;

    alu_op_t              w_decOp;
    logic [WORD_SIZE-1:0] w_corr;
    logic [WORD_SIZE-1:0] w_opB;
    logic                 w_cinInit;
    logic                 w_subMode;
    logic                 w_dc;

    alu_op_t              r_op;
    logic [WORD_SIZE-1:0] r_opA;
    logic [WORD_SIZE-1:0] r_opB;
    logic                 r_carry;
    logic                 r_subMode;
    logic                 r_dc;
    logic                 r_zlo;

    logic [WORD_SIZE-1:0] r_result;
    logic                 r_done;
    logic                 r_resultWe;
    logic                 r_zero;
    logic                 r_carryOut;
    logic                 r_halfOut;
    logic                 r_daaOut;

    logic [NIBBLE-1:0]    w_nibA;
    logic [NIBBLE-1:0]    w_nibB;
    logic [NIBBLE-1:0]    w_nibSum;
    logic                 w_nibCout;
    logic                 w_nibZero;

    logic                 w_carryFinal;
    logic                 w_halfFinal;
    logic                 w_daaFinal;

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: a request only starts from idle; requests seen during the
    // passes are dropped rather than queued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (alu.start) w_nextState = ST_LO;
            ST_LO:   w_nextState = ST_HI;
            ST_HI:   w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: ready covers the done cycle too, since done is registered
    // and the state is already back in idle when it is visible.
    always_comb begin
        w_ready  = (r_state == ST_IDLE);
        w_accept = w_ready && alu.start;
        w_loadLo = (r_state == ST_LO);
        w_loadHi = (r_state == ST_HI);
    end

    // Operand preparation at accept: subtraction becomes a + ~b + cin, and the
    // DAA correction is chosen here from the incoming accumulator and flags so
    // both passes just run a plain add of the latched operands.
    always_comb begin
        w_decOp   = decodeOp(alu.op);
        w_corr    = '0;
        w_dc      = 1'b0;
        w_opB     = alu.b;
        w_cinInit = 1'b0;
        w_subMode = 1'b0;
        case (w_decOp)
            ALU_ADC: begin
                w_cinInit = alu.carry_flag;
            end
            ALU_SUB, ALU_CP: begin
                w_opB     = ~alu.b;
                w_cinInit = 1'b1;
                w_subMode = 1'b1;
            end
            ALU_SBC: begin
                w_opB     = ~alu.b;
                w_cinInit = ~alu.carry_flag;
                w_subMode = 1'b1;
            end
            ALU_DAA: begin
                if (!alu.neg_flag) begin
                    if (alu.carry_flag || (alu.a > WORD_SIZE'(8'h99))) begin
                        w_corr = w_corr | WORD_SIZE'(DAA_HI_CORR);
                        w_dc   = 1'b1;
                    end
                    if (alu.half_carry_flag || (alu.a[NIBBLE-1:0] > NIBBLE'(9))) begin
                        w_corr = w_corr | WORD_SIZE'(DAA_LO_CORR);
                    end
                    w_opB = w_corr;
                end else begin
                    if (alu.carry_flag) begin
                        w_corr = w_corr | WORD_SIZE'(DAA_HI_CORR);
                    end
                    if (alu.half_carry_flag) begin
                        w_corr = w_corr | WORD_SIZE'(DAA_LO_CORR);
                    end
                    w_dc      = alu.carry_flag;
                    w_opB     = ~w_corr;
                    w_cinInit = 1'b1;
                    w_subMode = 1'b1;
                end
            end
            default: begin
                w_opB = alu.b;
            end
        endcase
    end

    // The single slice sees the low nibble in LO and the high nibble in HI;
    // r_carry holds the initial carry-in, then c4 between the passes.
    always_comb begin
        w_nibA = (r_state == ST_LO) ? r_opA[NIBBLE-1:0] : r_opA[WORD_SIZE-1:NIBBLE];
        w_nibB = (r_state == ST_LO) ? r_opB[NIBBLE-1:0] : r_opB[WORD_SIZE-1:NIBBLE];
    end

    sm83_alu_nibble #(
        .NIBBLE (NIBBLE)
    ) u_nibble (
        .i_a    (w_nibA),
        .i_b    (w_nibB),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_sum  (w_nibSum),
        .o_cout (w_nibCout),
        .o_zero (w_nibZero)
    );

    // Final flag mapping for the high pass: subtract-style ops report borrow
    // (inverted carry), logical ops use fixed values, DAA never reports H.
    always_comb begin
        w_carryFinal = w_nibCout ^ r_subMode;
        w_halfFinal  = r_carry ^ r_subMode;
        w_daaFinal   = 1'b0;
        case (r_op)
            ALU_AND: begin
                w_carryFinal = 1'b0;
                w_halfFinal  = 1'b1;
            end
            ALU_XOR, ALU_OR: begin
                w_carryFinal = 1'b0;
                w_halfFinal  = 1'b0;
            end
            ALU_DAA: begin
                w_halfFinal = 1'b0;
                w_daaFinal  = r_dc;
            end
            default: begin
                w_daaFinal = 1'b0;
            end
        endcase
    end

    // Datapath registers: latch operands at accept, build the result one
    // nibble per pass, and pulse done/result_we for exactly one cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_op       <= ALU_ADD;
            r_opA      <= '0;
            r_opB      <= '0;
            r_carry    <= 1'b0;
            r_subMode  <= 1'b0;
            r_dc       <= 1'b0;
            r_zlo      <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_resultWe <= 1'b0;
            r_zero     <= 1'b0;
            r_carryOut <= 1'b0;
            r_halfOut  <= 1'b0;
            r_daaOut   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_resultWe <= 1'b0;
            if (w_accept) begin
                r_op      <= w_decOp;
                r_opA     <= alu.a;
                r_opB     <= w_opB;
                r_carry   <= w_cinInit;
                r_subMode <= w_subMode;
                r_dc      <= w_dc;
            end
            if (w_loadLo) begin
                r_result[NIBBLE-1:0] <= w_nibSum;
                r_carry              <= w_nibCout;
                r_zlo                <= w_nibZero;
            end
            if (w_loadHi) begin
                r_result[WORD_SIZE-1:NIBBLE] <= w_nibSum;
                r_zero     <= r_zlo && w_nibZero;
                r_carryOut <= w_carryFinal;
                r_halfOut  <= w_halfFinal;
                r_daaOut   <= w_daaFinal;
                r_done     <= 1'b1;
                r_resultWe <= (r_op != ALU_CP);
            end
        end
    end

    assign alu.ready          = w_ready;
    assign alu.result         = r_result;
    assign alu.result_we      = r_resultWe;
    assign alu.done           = r_done;
    assign alu.zero_out       = r_zero;
    assign alu.carry_out      = r_carryOut;
    assign alu.half_carry_out = r_halfOut;
    assign alu.daa_carry_out  = r_daaOut;

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_sm83_alu_nibble_seq
// Self-checking bench for sm83_alu_nibble_seq. Expected results come from a
// whole-byte reference model, are queued when a request is accepted and are
// compared when done pulses.
// ---------------------------------------------------------------------------
module tb_sm83_alu_nibble_seq;

    typedef struct {
        logic [7:0] result;
        logic       we;
        logic       zero;
        logic       carry;
        logic       half;
        logic       daa;
        logic       chkCarry;
        int         acceptCyc;
    } expT;

    logic clk;
    logic nreset;
    int   cyc;
    int   vectorCount;
    int   missCount;
    int   doneCount;
    int   pushCount;
    logic prevDone;
    expT  sbQueue[$];
    expT  monExp;

    sm83_alu_nibble_seq_if #(.WORD_SIZE(8)) bus ();

    sm83_alu_nibble_seq dut (
        .clk    (clk),
        .nreset (nreset),
        .alu    (bus)
    );

    // Free-running clock and cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Whole-byte reference model of every operation.
    function automatic expT modelAlu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                     input logic cf, input logic hf, input logic nf);
        expT e;
        int ai, bi, alo, blo, ci, s;
        logic [7:0] corr;
        logic dc;
        ai = int'(a); bi = int'(b); alo = int'(a[3:0]); blo = int'(b[3:0]); ci = int'(cf);
        e.we = 1'b1; e.chkCarry = 1'b1; e.daa = 1'b0; e.acceptCyc = 0;
        e.carry = 1'b0; e.half = 1'b0; e.result = 8'h00;
        case (op)
            4'd0, 4'd1: begin
                if (op == 4'd0) ci = 0;
                s = ai + bi + ci;
                e.result = s[7:0];
                e.carry  = (s > 255);
                e.half   = (alo + blo + ci > 15);
            end
            4'd2, 4'd3, 4'd7: begin
                if (op != 4'd3) ci = 0;
                s = ai - bi - ci;
                e.result = s[7:0];
                e.carry  = (ai < bi + ci);
                e.half   = (alo < blo + ci);
                e.we     = (op != 4'd7);
            end
            4'd4: begin e.result = a & b; e.half = 1'b1; end
            4'd5: e.result = a ^ b;
            4'd8: begin
                corr = 8'h00; dc = 1'b0;
                if (!nf) begin
                    if (cf || a > 8'h99) begin corr = corr | 8'h60; dc = 1'b1; end
                    if (hf || a[3:0] > 4'd9) corr = corr | 8'h06;
                    e.result = a + corr;
                end else begin
                    if (cf) corr = corr | 8'h60;
                    if (hf) corr = corr | 8'h06;
                    dc = cf;
                    e.result = a - corr;
                end
                e.daa = dc;
                e.chkCarry = 1'b0;
            end
            default: e.result = a | b;
        endcase
        e.zero = (e.result == 8'h00);
        return e;
    endfunction

    // Monitor: on every done pulse pop the oldest expectation and compare;
    // a done with nothing outstanding, or a done two cycles running, fails.
    always @(negedge clk) begin
        if (bus.done) begin
            doneCount <= doneCount + 1;
            checkOutput("done_prev_low", prevDone, 0);
            if (sbQueue.size() == 0) begin
                checkOutput("done_expected", 0, 1);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("result", bus.result, monExp.result);
                checkOutput("result_we", bus.result_we, monExp.we);
                checkOutput("zero_out", bus.zero_out, monExp.zero);
                checkOutput("half_carry_out", bus.half_carry_out, monExp.half);
                checkOutput("daa_carry_out", bus.daa_carry_out, monExp.daa);
                if (monExp.chkCarry) checkOutput("carry_out", bus.carry_out, monExp.carry);
                checkOutput("latency", cyc - monExp.acceptCyc, 2);
            end
        end
        prevDone <= bus.done;
    end

    // Waits (bounded) for ready, drives one request and queues its expectation.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cf, input logic hf, input logic nf);
        int waitCnt;
        expT e;
        waitCnt = 0;
        @(negedge clk);
        while (!bus.ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        bus.op = op; bus.a = a; bus.b = b;
        bus.carry_flag = cf; bus.half_carry_flag = hf; bus.neg_flag = nf;
        bus.start = 1'b1;
        e = modelAlu(op, a, b, cf, hf, nf);
        e.acceptCyc = cyc + 1;
        sbQueue.push_back(e);
        pushCount++;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQueue.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sbQueue.size(), 0);
        @(negedge clk);
    endtask

    // start held high every cycle: only idle cycles may accept.
    task automatic backToBack();
        int accepts;
        expT e;
        accepts = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.op = (i % 2 == 0) ? 4'd0 : 4'd5;
            bus.a = 8'($urandom_range(0, 255));
            bus.b = 8'($urandom_range(0, 255));
            bus.carry_flag = 1'b0; bus.half_carry_flag = 1'b0; bus.neg_flag = 1'b0;
            bus.start = 1'b1;
            if (bus.ready) begin
                e = modelAlu(bus.op, bus.a, bus.b, 1'b0, 1'b0, 1'b0);
                e.acceptCyc = cyc + 1;
                sbQueue.push_back(e);
                pushCount++;
                accepts++;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("b2b_accepts", accepts, 3);
    endtask

    task automatic resetMidOp();
        int doneBefore;
        expT e;
        @(negedge clk);
        bus.op = 4'd0; bus.a = 8'h55; bus.b = 8'h11;
        bus.carry_flag = 1'b0; bus.half_carry_flag = 1'b0; bus.neg_flag = 1'b0;
        bus.start = 1'b1;
        e = modelAlu(4'd0, 8'h55, 8'h11, 1'b0, 1'b0, 1'b0);
        sbQueue.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        sbQueue.delete();
        doneBefore = doneCount;
        checkOutput("rst_mid_ready", bus.ready, 1);
        checkOutput("rst_mid_result", bus.result, 0);
        checkOutput("rst_mid_done", bus.done, 0);
        checkOutput("rst_mid_carry", bus.carry_out, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rst_no_done", doneCount, doneBefore);
        applyStimulus(4'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc = 0; vectorCount = 0; missCount = 0; doneCount = 0; pushCount = 0;
        prevDone = 1'b0;
        nreset = 1'b0;
        bus.start = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
        bus.carry_flag = 1'b0; bus.half_carry_flag = 1'b0; bus.neg_flag = 1'b0;
        #12;
        checkOutput("rst_ready", bus.ready, 1);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_result_we", bus.result_we, 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_zero", bus.zero_out, 0);
        checkOutput("rst_carry", bus.carry_out, 0);
        checkOutput("rst_half", bus.half_carry_out, 0);
        checkOutput("rst_daa", bus.daa_carry_out, 0);
        @(negedge clk);
        nreset = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(4'd0, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd3, 8'h3B, 8'h2A, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd7, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd8, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd8, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd8, 8'h45, 8'h00, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd4, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd12, 8'h50, 8'h05, 1'b1, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] random vectors");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        waitDrain();

        $display("[TB] back-to-back");
        backToBack();
        waitDrain();

        $display("[TB] reset during high pass");
        resetMidOp();
        waitDrain();

        checkOutput("done_count", doneCount, pushCount);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
